// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 5-stage 64-bit ARM core
//               pipeline control: sequencer state encoding, EX operand
//               forwarding-source encoding, the zero register index and the
//               per-operand forwarding selection function.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Pipeline sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    // EX operand source encoding
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read in ID
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB write-back data

    // X31 reads as zero, so it never carries a forwardable result
    localparam logic [4:0] XZR = 5'd31;

    // The younger producer (MEM) wins over the older one (WB) so that the
    // most recent write to a register is the one forwarded.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_rd,
        input logic       wb_wr,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != XZR) begin
            if (mem_wr && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_wr && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Purely combinational EX operand forwarding compare. Selects
//               the source of both EX operands (Rn -> A, Rm -> B) from the
//               register file, the EX/MEM result or the MEM/WB write data.
// Ports       : ex_rn_i/ex_rm_i     EX source registers
//               mem_rd_i/mem_regwr_i  destination/write flag in MEM
//               wb_rd_i/wb_regwr_i    destination/write flag leaving MEM/WB
//               fwd_a_o/fwd_b_o       operand source selects
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] ex_rn_i,
    input  logic [4:0] ex_rm_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwr_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwr_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    assign fwd_a_o = fwd_pick(ex_rn_i, mem_regwr_i, mem_rd_i, wb_regwr_i, wb_rd_i);
    assign fwd_b_o = fwd_pick(ex_rm_i, mem_regwr_i, mem_rd_i, wb_regwr_i, wb_rd_i);

endmodule
`default_nettype wire

// File: rtl/hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sched
// Description : Pipeline sequencer for the 5-stage 64-bit ARM core. Drives the
//               PC and pipeline-register enables, flush/bubble controls and EX
//               forwarding selects; resolves load-use, taken-branch and
//               multi-cycle data-memory stalls with a small FSM, a memory-wait
//               watchdog and a saturating stall-cycle counter.
// Ports       : clk, reset (async, active low)
//               id_*   : ID-stage source registers and read flags
//               ex_*   : EX-stage destination/load flags and source registers
//               mem_*, wb_* : later-stage destinations for forwarding
//               br_taken_ex, dmem_req, dmem_ready : stall/flush causes
//               *_en, if_id_flush, id_ex_bubble, mem_wb_bubble : pipe control
//               fwd_a, fwd_b : EX operand sources
//               mem_err : sticky watchdog fault; stall_cnt : cycles with pc_en=0
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwr,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwr,
    input  logic             br_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int C_WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    // The RUN cycle that detects the miss is the first frozen cycle, so the
    // fault is raised on the frozen cycle whose incremented count reaches
    // MEM_TIMEOUT-1: MEM_TIMEOUT frozen cycles in total precede ERR.
    localparam logic [C_WCNT_W-1:0] C_WCNT_LAST = C_WCNT_W'(MEM_TIMEOUT - 2);

    state_e              state_q;
    state_e              state_d;
    logic [C_WCNT_W-1:0] wcnt_q;
    logic [C_WCNT_W-1:0] wcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic                mem_err_q;

    logic                w_load_use;
    logic                w_advance;
    logic [1:0]          w_fwd_a;
    logic [1:0]          w_fwd_b;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_unit u_fwd (
        .ex_rn_i     (ex_rn),
        .ex_rm_i     (ex_rm),
        .mem_rd_i    (mem_rd),
        .mem_regwr_i (mem_regwr),
        .wb_rd_i     (wb_rd),
        .wb_regwr_i  (wb_regwr),
        .fwd_a_o     (w_fwd_a),
        .fwd_b_o     (w_fwd_b)
    );

    assign fwd_a = reset ? w_fwd_a : FWD_RF;
    assign fwd_b = reset ? w_fwd_b : FWD_RF;

    // A load in EX whose destination is read by the instruction in ID cannot
    // be forwarded in time; one stall lets it reach MEM first.
    assign w_load_use = ex_memrd && ex_regwr && (ex_rd != XZR) &&
                        ((id_use_rn && (id_rn == ex_rd)) ||
                         (id_use_rm && (id_rm == ex_rd)));

    // ------------------------------------------------------------------
    // FSM next state and pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        w_advance     = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    mem_wb_bubble = 1'b1;
                    wcnt_d        = '0;
                    state_d       = MEM_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_advance = 1'b1;
                    wcnt_d    = '0;
                    state_d   = RUN;
                end else begin
                    mem_wb_bubble = 1'b1;
                    wcnt_d        = wcnt_q + 1'b1;
                    if (wcnt_q == C_WCNT_LAST) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                mem_wb_bubble = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Advancing cycle: the branch squash outranks load-use because the
        // instruction sitting in ID is on the wrong path anyway.
        if (w_advance) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (br_taken_ex) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        // Hold the whole pipeline inert while reset is applied.
        if (!reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, watchdog, fault flag and stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_d == ERR) begin
                mem_err_q <= 1'b1;
            end
            if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sched
// Description : Self-checking bench for hazard_sched (MEM_TIMEOUT=8, CNT_W=4).
//               Expected output vectors are queued as stimulus is applied and
//               popped when the DUT outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd, ex_rn, ex_rm, mem_rd, wb_rd;
    logic       id_use_rn, id_use_rm, ex_regwr, ex_memrd, mem_regwr, wb_regwr;
    logic       br_taken_ex, dmem_req, dmem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_bubble, mem_wb_bubble, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_sched #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
        .ex_rn(ex_rn), .ex_rm(ex_rm),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .br_taken_ex(br_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    // {5 enables, flush, id_ex_bubble, mem_wb_bubble, fwd_a, fwd_b, mem_err, stall_cnt}
    wire [16:0] obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_bubble, mem_wb_bubble,
                       fwd_a, fwd_b, mem_err, stall_cnt};

    localparam logic [7:0] C_RUN   = 8'b11111_000;
    localparam logic [7:0] C_STALL = 8'b00000_001;
    localparam logic [7:0] C_LDUSE = 8'b00111_010;
    localparam logic [7:0] C_BR    = 8'b11111_110;
    localparam logic [7:0] C_NONE  = 8'b00000_000;

    logic [16:0] exp_q[$];
    logic [16:0] expv;
    logic [3:0]  exp_stall;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [16:0] mk(input logic [7:0] ctl, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic err,
                                       input logic [3:0] sc);
        return {ctl, fa, fb, err, sc};
    endfunction

    // Reference stall counter: counts cycles whose expected pc_en is 0.
    task automatic adv_stall(input logic [16:0] e);
        if (!e[16] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    endtask

    task automatic clear_in();
        id_rn = 5'd0; id_rm = 5'd0; id_use_rn = 1'b0; id_use_rm = 1'b0;
        ex_rd = 5'd0; ex_regwr = 1'b0; ex_memrd = 1'b0; ex_rn = 5'd0; ex_rm = 5'd0;
        mem_rd = 5'd0; mem_regwr = 1'b0; wb_rd = 5'd0; wb_regwr = 1'b0;
        br_taken_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_in();
            reset = 1'b0;
            mem_regwr = 1'b1; mem_rd = 5'd5; ex_rn = 5'd5; dmem_req = 1'b1;
            exp_q.push_back(mk(C_NONE, 2'b00, 2'b00, 1'b0, 4'd0));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
        exp_stall = 4'd0;
        @(negedge clk);
        clear_in();
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        logic [1:0] fa, fb;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_in();
            case (i)
                0: begin mem_regwr=1; mem_rd=5;  wb_regwr=1; wb_rd=5;  ex_rn=5;  ex_rm=7;  fa=2'b01; fb=2'b00; end
                1: begin mem_regwr=1; mem_rd=31; wb_regwr=1; wb_rd=31; ex_rn=31; ex_rm=31; fa=2'b00; fb=2'b00; end
                2: begin mem_regwr=0; mem_rd=5;  wb_regwr=1; wb_rd=5;  ex_rn=5;  ex_rm=5;  fa=2'b10; fb=2'b10; end
                3: begin mem_regwr=1; mem_rd=3;  wb_regwr=1; wb_rd=5;  ex_rn=5;  ex_rm=3;  fa=2'b10; fb=2'b01; end
                default: begin mem_regwr=1; mem_rd=5; wb_regwr=0; wb_rd=5; ex_rn=2; ex_rm=5; fa=2'b00; fb=2'b01; end
            endcase
            exp_q.push_back(mk(C_RUN, fa, fb, 1'b0, exp_stall));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL fwd[%0d] got=%h exp=%h", i, obs, expv);
            end
            adv_stall(expv);
        end
    endtask

    task automatic test_load_use();
        logic [7:0] ctl;
        logic [1:0] fa;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_in();
            fa = 2'b00;
            case (i)
                // LDUR X2 in EX, ADD reading X2 in ID
                0: begin ex_memrd=1; ex_regwr=1; ex_rd=2; id_rn=2; id_use_rn=1; ctl=C_LDUSE; end
                // load now in MEM, ADD in EX picks it up from EX/MEM
                1: begin mem_regwr=1; mem_rd=2; ex_rn=2; ctl=C_RUN; fa=2'b01; end
                // hazard through Rm only
                2: begin ex_memrd=1; ex_regwr=1; ex_rd=4; id_rn=4; id_rm=4; id_use_rm=1; ctl=C_LDUSE; end
                // load into XZR is never a hazard
                3: begin ex_memrd=1; ex_regwr=1; ex_rd=31; id_rn=31; id_use_rn=1; ctl=C_RUN; end
                // matching register that is not actually read
                4: begin ex_memrd=1; ex_regwr=1; ex_rd=6; id_rn=6; id_rm=6; ctl=C_RUN; end
                // non-load producer forwards, no stall
                default: begin ex_regwr=1; ex_rd=6; id_rn=6; id_use_rn=1; ctl=C_RUN; end
            endcase
            exp_q.push_back(mk(ctl, fa, 2'b00, 1'b0, exp_stall));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, expv);
            end
            adv_stall(expv);
        end
    endtask

    // Three frozen cycles then ready; second pass holds a taken branch.
    task automatic test_mem_wait();
        logic [7:0] ctl;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                clear_in();
                br_taken_ex = (p == 1);
                dmem_req    = (i < 4);
                dmem_ready  = (i == 3);
                if (i < 3)       ctl = C_STALL;
                else if (p == 1) ctl = C_BR;
                else             ctl = C_RUN;
                if (i == 4) br_taken_ex = 1'b0;
                if (i == 4) ctl = C_RUN;
                exp_q.push_back(mk(ctl, 2'b00, 2'b00, 1'b0, exp_stall));
                #1;
                expv = exp_q.pop_front();
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL mem_wait[%0d.%0d] got=%h exp=%h", p, i, obs, expv);
                end
                adv_stall(expv);
            end
        end
    endtask

    task automatic test_branch_vs_load_use();
        @(negedge clk);
        clear_in();
        br_taken_ex = 1'b1;
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; id_use_rn = 1'b1;
        exp_q.push_back(mk(C_BR, 2'b00, 2'b00, 1'b0, exp_stall));
        #1;
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL br_vs_lu got=%h exp=%h", obs, expv);
        end
        adv_stall(expv);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req   = 1'b1;
            dmem_ready = (i == 10);
            exp_q.push_back(mk(C_STALL, 2'b00, 2'b00, (i >= 8), exp_stall));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, expv);
            end
            adv_stall(expv);
        end
        // asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        #1;
        reset = 1'b0;
        exp_stall = 4'd0;
        exp_q.push_back(mk(C_NONE, 2'b00, 2'b00, 1'b0, 4'd0));
        #1;
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, expv);
        end
        @(negedge clk);
        clear_in();
        reset = 1'b1;
        exp_q.push_back(mk(C_RUN, 2'b00, 2'b00, 1'b0, exp_stall));
        #1;
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL after_reset got=%h exp=%h", obs, expv);
        end
        adv_stall(expv);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req = 1'b1;
            exp_q.push_back(mk(C_STALL, 2'b00, 2'b00, (i >= 8), exp_stall));
            #1;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL saturate[%0d] got=%h exp=%h", i, obs, expv);
            end
            adv_stall(expv);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'hF) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=f", stall_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        exp_stall = 4'd0;
        clear_in();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch_vs_load_use();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
